// File: rtl/uart_tx_if.sv
// uart_tx_if: CPU data-bus signals seen by the UART transmitter peripheral.
// The CPU side drives the request; the peripheral returns read data.
interface uart_tx_if;
    logic [31:0] addr;
    logic        en;
    logic        we;
    logic [3:0]  byte_sel;
    logic [31:0] data_in;
    logic [31:0] data_out;

    modport master (
        output addr, en, we, byte_sel, data_in,
        input  data_out
    );

    modport slave (
        input  addr, en, we, byte_sel, data_in,
        output data_out
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: memory-mapped UART transmitter with a 4-entry byte FIFO.
// DATA at BASE_ADDR (write pushes a byte), STATUS at BASE_ADDR+4
// ({ovf, count, empty, full, busy}, ovf is write-1-clear on bit 6).
// Build option: define UART_TX_PARITY_EN for 8E1 frames (STATUS bit 7 = 1);
// otherwise frames are 8N1 and STATUS bit 7 = 0.
module uart_tx #(
    parameter int          CLKS_PER_BIT = 43,
    parameter logic [31:0] BASE_ADDR    = 32'hFFFFFC40
) (
    input  logic       clk,
    input  logic       rst,
    uart_tx_if.slave   bus,
    output logic       tx
);

    localparam int                BAUD_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [31:0]       STATUS_ADDR = BASE_ADDR + 32'd4;

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_BUILD = 1'b1;
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;
`else
    localparam logic PARITY_BUILD = 1'b0;
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4} state_t;
`endif

    // Bus decode
    logic data_wr;
    logic status_wr;
    assign data_wr   = bus.en && bus.we && bus.byte_sel[0] && (bus.addr == BASE_ADDR);
    assign status_wr = bus.en && bus.we && bus.byte_sel[0] && (bus.addr == STATUS_ADDR);

    // Upper write-data bits and lanes 1..3 carry nothing for this block.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.data_in[31:8], bus.byte_sel[3:1]};

    // FIFO
    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       pop;
    logic       push;
    logic       overflow;

    assign full     = (count == 3'd4);
    assign empty    = (count == 3'd0);
    // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
    assign push     = data_wr && (!full || pop);
    assign overflow = data_wr && full && !pop;

    // FSM / shifter state
    state_t            state, state_d;
    logic [7:0]        sh, sh_d;
    logic [2:0]        bit_cnt, bit_cnt_d;
    logic [BAUD_W-1:0] baud, baud_d;
    logic              tx_d;
    logic              baud_done;
`ifdef UART_TX_PARITY_EN
    logic              par, par_d;
`endif

    assign baud_done = (baud == BAUD_LAST);

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (overflow)
                ovf <= 1'b1;
            else if (status_wr && bus.data_in[6])
                ovf <= 1'b0;
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers and count define which entries are valid.
        if (push) fifo_mem[wr_ptr] <= bus.data_in[7:0];
    end

    // FSM state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sh      <= '0;
            bit_cnt <= '0;
            baud    <= '0;
            tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            sh      <= sh_d;
            bit_cnt <= bit_cnt_d;
            baud    <= baud_d;
            tx      <= tx_d;
`ifdef UART_TX_PARITY_EN
            par     <= par_d;
`endif
        end
    end

    // Next-state, frame sequencing and FIFO pop
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d   = state;
        sh_d      = sh;
        bit_cnt_d = bit_cnt;
        baud_d    = baud;
        tx_d      = tx;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d     = par;
`endif
        case (state)
            IDLE: begin
                baud_d    = '0;
                bit_cnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    sh_d    = fifo_mem[rd_ptr];
                    tx_d    = 1'b0;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^fifo_mem[rd_ptr];
`endif
                end else begin
                    tx_d = 1'b1;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    tx_d    = sh[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = par;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        sh_d      = sh >> 1;
                        tx_d      = sh[1];
                        bit_cnt_d = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = STOP;
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // Combinational register read-back
    logic        busy;
    logic [31:0] status;
    assign busy   = (state != IDLE) || !empty;
    assign status = {24'b0, PARITY_BUILD, ovf, count, empty, full, busy};

    always_comb begin
        bus.data_out = 32'h0;
        if (bus.addr == STATUS_ADDR) bus.data_out = status;
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx with CLKS_PER_BIT=4.
// A serial monitor decodes frames on tx and compares them with a queue of
// bytes pushed when writes are issued; register behaviour is table-driven.
module tb_uart_tx;

    localparam int          CPB         = 4;
    localparam logic [31:0] BASE        = 32'hFFFFFC40;
    localparam logic [31:0] STATUS_ADDR = BASE + 32'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [31:0] PBIT  = 32'h80;
    localparam int          FRAME = 11 * CPB;
`else
    localparam logic [31:0] PBIT  = 32'h00;
    localparam int          FRAME = 10 * CPB;
`endif
    localparam logic [31:0] ST_IDLE = 32'h04 | PBIT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    uart_tx_if bus ();

    uart_tx #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard and serial monitor
    logic [7:0] sb[$];
    int         starts[$];
    int         frames = 0;
    bit         mon_abort = 0;
    logic [7:0] mon_byte;
    logic [7:0] mon_exp;
    logic       mon_start;
    logic       mon_stop;
    logic       mon_par;

    initial forever begin
        @(posedge clk);
        if (rst) mon_abort = 1;
    end

    initial forever begin
        @(negedge clk);
        if (tx === 1'b0) begin
            mon_abort = 0;
            starts.push_back(cyc);
            repeat (2) @(negedge clk);
            mon_start = tx;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                mon_byte[i] = tx;
            end
`ifdef UART_TX_PARITY_EN
            repeat (CPB) @(negedge clk);
            mon_par = tx;
`else
            mon_par = ^mon_byte;
`endif
            repeat (CPB) @(negedge clk);
            mon_stop = tx;
            if (!mon_abort) begin
                frames++;
                check("start_bit", 32'(mon_start), 0);
                check("stop_bit", 32'(mon_stop), 1);
                check("parity_bit", 32'(mon_par), 32'(^mon_byte));
                check("frame_queued", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    mon_exp = sb.pop_front();
                    check("frame_byte", 32'(mon_byte), 32'(mon_exp));
                end
            end
        end
    end

    // Bus helpers (caller sits just after a negedge)
    task automatic bus_idle();
        bus.en       = 1'b0;
        bus.we       = 1'b0;
        bus.byte_sel = 4'h0;
        bus.data_in  = 32'h0;
        bus.addr     = STATUS_ADDR;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] bs);
        bus.addr     = a;
        bus.en       = 1'b1;
        bus.we       = 1'b1;
        bus.byte_sel = bs;
        bus.data_in  = d;
        @(posedge clk);
        @(negedge clk);
        bus_idle();
    endtask

    task automatic read_status(output logic [31:0] s);
        bus.addr = STATUS_ADDR;
        #1;
        s = bus.data_out;
    endtask

    task automatic wait_idle(input int bound);
        logic [31:0] s;
        int          n;
        n = 0;
        read_status(s);
        while (s[0] === 1'b1 && n <= bound) begin
            @(negedge clk);
            n++;
            read_status(s);
        end
        if (n > bound) check("idle_timeout", 32'(n), 32'(bound));
    endtask

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        en;
        logic        we;
        logic [3:0]  bsel;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [31:0] exp_status;
    } vec_t;

    vec_t        vecs[8];
    logic [31:0] st;
    int          k;
    int          lows;
    int          frames_before;

    initial begin
        vecs[0] = '{"wr_base_plus8", BASE + 32'd8, 1'b1, 1'b1, 4'hF,    32'h55,       32'h0,   ST_IDLE};
        vecs[1] = '{"wr_lane_mask",  BASE,         1'b1, 1'b1, 4'b1110, 32'h5A,       32'h0,   ST_IDLE};
        vecs[2] = '{"wr_no_en",      BASE,         1'b0, 1'b1, 4'hF,    32'h5A,       32'h0,   ST_IDLE};
        vecs[3] = '{"rd_data",       BASE,         1'b1, 1'b0, 4'hF,    32'h5A,       32'h0,   ST_IDLE};
        vecs[4] = '{"rd_status",     STATUS_ADDR,  1'b1, 1'b0, 4'hF,    32'h0,        ST_IDLE, ST_IDLE};
        vecs[5] = '{"rd_unmapped",   32'h0,        1'b1, 1'b0, 4'hF,    32'h0,        32'h0,   ST_IDLE};
        vecs[6] = '{"wr_status_idle", STATUS_ADDR, 1'b1, 1'b1, 4'h1,    32'hFFFFFFFF, ST_IDLE, ST_IDLE};
        vecs[7] = '{"rd_base_minus4", BASE - 32'd4, 1'b1, 1'b0, 4'hF,   32'h0,        32'h0,   ST_IDLE};

        bus_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_tx", 32'(tx), 1);
        read_status(st);
        check("reset_status", st, ST_IDLE);

        // Register decode table
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.addr     = vecs[i].addr;
            bus.en       = vecs[i].en;
            bus.we       = vecs[i].we;
            bus.byte_sel = vecs[i].bsel;
            bus.data_in  = vecs[i].wdata;
            #1;
            check({vecs[i].name, "_rd"}, bus.data_out, vecs[i].exp_rd);
            @(posedge clk);
            @(negedge clk);
            bus_idle();
            read_status(st);
            check({vecs[i].name, "_status"}, st, vecs[i].exp_status);
        end
        check("decode_tx_idle", 32'(tx), 1);

        // Single byte: latency and busy duration
        @(negedge clk);
        sb.push_back(8'hA5);
        bus_write(BASE, 32'hFFFF_FFA5, 4'h1);
        k = cyc;
        check("latency_tx_high", 32'(tx), 1);
        @(negedge clk);
        check("latency_tx_low", 32'(tx), 0);
        wait_idle(200);
        check("single_busy_cycles", 32'(cyc - k), 32'(FRAME + 1));
        check("single_sb_drained", 32'(sb.size()), 0);

        // Burst of five, overflow on the sixth, then W1C
        for (int i = 1; i <= 5; i++) begin
            sb.push_back(8'(i));
            bus_write(BASE, 32'(i), 4'h1);
        end
        read_status(st);
        check("burst_full_status", st, 32'h23 | PBIT);
        bus_write(BASE, 32'h66, 4'h1);
        read_status(st);
        check("burst_ovf_status", st, 32'h63 | PBIT);
        bus_write(STATUS_ADDR, 32'h40, 4'h1);
        read_status(st);
        check("burst_w1c_status", st, 32'h23 | PBIT);
        wait_idle(400);
        check("burst_sb_drained", 32'(sb.size()), 0);
        read_status(st);
        check("burst_idle_status", st, ST_IDLE);

        // Back-to-back frame spacing
        starts.delete();
        sb.push_back(8'h00);
        bus_write(BASE, 32'h00, 4'h1);
        sb.push_back(8'hFF);
        bus_write(BASE, 32'hFF, 4'h1);
        wait_idle(200);
        check("b2b_frames", 32'(starts.size()), 2);
        if (starts.size() == 2)
            check("b2b_period", 32'(starts[1] - starts[0]), 32'(FRAME + 1));
        check("b2b_sb_drained", 32'(sb.size()), 0);

        // Reset during data bit 3, coinciding with a DATA write
        bus_write(BASE, 32'h11, 4'h1);
        k = cyc;
        bus_write(BASE, 32'h22, 4'h1);
        bus_write(BASE, 32'h33, 4'h1);
        while (cyc < k + 18) @(negedge clk);
        check("midframe_bit3", 32'(tx), 0);
        rst          = 1'b1;
        bus.addr     = BASE;
        bus.en       = 1'b1;
        bus.we       = 1'b1;
        bus.byte_sel = 4'h1;
        bus.data_in  = 32'h77;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus_idle();
        #1;
        check("rst_tx_high", 32'(tx), 1);
        read_status(st);
        check("rst_status", st, ST_IDLE);
        frames_before = frames;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("rst_no_frame_tx", 32'(lows), 0);
        check("rst_no_frame_count", 32'(frames), 32'(frames_before));
        read_status(st);
        check("rst_final_status", st, ST_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
